// File: rtl/contador_embalagem.sv
// contador_embalagem: bottle-per-box counter with conveyor gating and timed box exchange.
// Optional CONT_CAIXAS_EN adds total_caixas output and limpa_erro input.
module contador_embalagem #(
  parameter int GARRAFAS_POR_CAIXA = 6,
  parameter int TEMPO_TROCA = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       gc_in,
  input  logic       cx_presente,
`ifdef CONT_CAIXAS_EN
  input  logic       limpa_erro,
  output logic [7:0] total_caixas,
`endif
  output logic       esteira,
  output logic       troca_cx,
  output logic [3:0] cnt_garrafas,
  output logic       cx_cheia,
  output logic       erro,
  output logic [1:0] estado
);
  typedef enum logic [1:0] {ESPERA_CAIXA = 2'b00, ENCHENDO = 2'b01, TROCA = 2'b10, ERRO = 2'b11} state_t;
  state_t st, st_n;
  logic gc_prev, ev, erro_n, cheia_n;
  logic [3:0] cnt_n;
  logic [7:0] tmr, tmr_n;
  assign ev = gc_in & ~gc_prev;
  assign estado = st;
  always_comb begin
    st_n = st;
    cnt_n = cnt_garrafas;
    tmr_n = tmr;
    erro_n = erro;
    cheia_n = 1'b0;
`ifdef CONT_CAIXAS_EN
    if (st == ESPERA_CAIXA && limpa_erro) erro_n = 1'b0;
`endif
    case (st)
      ESPERA_CAIXA:
        if (ev) begin
          st_n = ERRO;
          erro_n = 1'b1;
        end else if (cx_presente) begin
          st_n = ENCHENDO;
          cnt_n = 4'd0;
        end
      ENCHENDO:
        if (ev && !cx_presente) begin
          st_n = ERRO;
          erro_n = 1'b1;
        end else if (ev) begin
          cnt_n = cnt_garrafas + 4'd1;
          if (cnt_n == 4'(GARRAFAS_POR_CAIXA)) begin
            st_n = TROCA;
            cheia_n = 1'b1;
            tmr_n = 8'(TEMPO_TROCA);
          end
        end else if (!cx_presente) begin
          st_n = cnt_garrafas == 4'd0 ? ESPERA_CAIXA : ERRO;
          erro_n = erro | (cnt_garrafas != 4'd0);
        end
      TROCA: begin
        if (ev) erro_n = 1'b1;
        if (tmr <= 8'd1) begin
          st_n = ESPERA_CAIXA;
          cnt_n = 4'd0;
          tmr_n = 8'd0;
        end else tmr_n = tmr - 8'd1;
      end
      default: st_n = cx_presente ? ERRO : ESPERA_CAIXA;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st <= ESPERA_CAIXA;
      gc_prev <= 1'b0;
      tmr <= 8'd0;
      cnt_garrafas <= 4'd0;
      erro <= 1'b0;
      cx_cheia <= 1'b0;
      esteira <= 1'b0;
      troca_cx <= 1'b0;
    end else begin
      st <= st_n;
      gc_prev <= gc_in;
      tmr <= tmr_n;
      cnt_garrafas <= cnt_n;
      erro <= erro_n;
      cx_cheia <= cheia_n;
      esteira <= st_n == ENCHENDO;
      troca_cx <= st_n == TROCA;
    end
`ifdef CONT_CAIXAS_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) total_caixas <= 8'd0;
    else total_caixas <= total_caixas + {7'd0, cheia_n};
`endif
endmodule

// File: tb/tb_contador_embalagem.sv
// tb_contador_embalagem: directed self-checking bench for contador_embalagem.
module tb_contador_embalagem;
  logic clk = 1'b0, reset = 1'b1, gc_in = 1'b0, cx_presente = 1'b0;
  logic esteira, troca_cx, cx_cheia, erro;
  logic [3:0] cnt_garrafas;
  logic [1:0] estado;
  int total = 0, bad = 0;
`ifdef CONT_CAIXAS_EN
  logic limpa_erro = 1'b0;
  logic [7:0] total_caixas;
`endif
  always #5 clk = ~clk;
  contador_embalagem dut (
    .clk(clk), .reset(reset), .gc_in(gc_in), .cx_presente(cx_presente),
`ifdef CONT_CAIXAS_EN
    .limpa_erro(limpa_erro), .total_caixas(total_caixas),
`endif
    .esteira(esteira), .troca_cx(troca_cx), .cnt_garrafas(cnt_garrafas),
    .cx_cheia(cx_cheia), .erro(erro), .estado(estado)
  );
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_reset();
    @(negedge clk);
    gc_in = 1'b0;
    cx_presente = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    total++;
    if ({estado, esteira, troca_cx, cnt_garrafas, cx_cheia, erro} !== 10'b0) begin
      bad++;
      $display("FAIL reset_state got %b want 0", {estado, esteira, troca_cx, cnt_garrafas, cx_cheia, erro});
    end
  endtask
  task automatic test_full_box();
    int n = 0;
    do_reset();
    cx_presente = 1'b1;
    tick();
    total++;
    if (estado !== 2'b01 || esteira !== 1'b1) begin
      bad++;
      $display("FAIL enter_fill estado=%b esteira=%b want 01/1", estado, esteira);
    end
    for (int i = 1; i <= 5; i++) begin
      gc_in = 1'b1;
      repeat (3) tick();
      gc_in = 1'b0;
      tick();
      total++;
      if (cnt_garrafas !== 4'(i)) begin
        bad++;
        $display("FAIL count_%0d got %0d want %0d", i, cnt_garrafas, i);
      end
    end
    gc_in = 1'b1;
    tick();
    total++;
    if ({cnt_garrafas, cx_cheia, estado, troca_cx, esteira} !== {4'd6, 1'b1, 2'b10, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL box_full cnt=%0d cheia=%b estado=%b troca=%b esteira=%b want 6/1/10/1/0",
               cnt_garrafas, cx_cheia, estado, troca_cx, esteira);
    end
    cx_presente = 1'b0;
    n = 1;
    for (int k = 0; k < 12 && troca_cx; k++) begin
      if (k == 2) gc_in = 1'b0;
      tick();
      if (k == 0) begin
        total++;
        if (cx_cheia !== 1'b0) begin
          bad++;
          $display("FAIL cheia_pulse got %b want 0", cx_cheia);
        end
      end
      if (troca_cx) n++;
    end
    total++;
    if (n != 4) begin
      bad++;
      $display("FAIL troca_len got %0d want 4", n);
    end
    total++;
    if ({estado, cnt_garrafas, esteira, erro} !== {2'b00, 4'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL after_troca estado=%b cnt=%0d esteira=%b erro=%b want 00/0/0/0", estado, cnt_garrafas, esteira, erro);
    end
  endtask
  task automatic test_long_pulse_and_removal();
    cx_presente = 1'b1;
    tick();
    gc_in = 1'b1;
    repeat (20) tick();
    total++;
    if (cnt_garrafas !== 4'd1) begin
      bad++;
      $display("FAIL long_pulse got %0d want 1", cnt_garrafas);
    end
    repeat (2) begin
      gc_in = 1'b0;
      tick();
      gc_in = 1'b1;
      tick();
    end
    gc_in = 1'b0;
    cx_presente = 1'b0;
    tick();
    total++;
    if ({estado, erro, cnt_garrafas, esteira} !== {2'b11, 1'b1, 4'd3, 1'b0}) begin
      bad++;
      $display("FAIL removal estado=%b erro=%b cnt=%0d esteira=%b want 11/1/3/0", estado, erro, cnt_garrafas, esteira);
    end
    tick();
    total++;
    if (estado !== 2'b00 || erro !== 1'b1) begin
      bad++;
      $display("FAIL err_exit estado=%b erro=%b want 00/1", estado, erro);
    end
  endtask
  task automatic test_ev_priority();
    do_reset();
    tick();
    gc_in = 1'b1;
    cx_presente = 1'b1;
    tick();
    total++;
    if (estado !== 2'b11 || erro !== 1'b1) begin
      bad++;
      $display("FAIL ev_priority estado=%b erro=%b want 11/1", estado, erro);
    end
    gc_in = 1'b0;
    repeat (2) tick();
    total++;
    if (estado !== 2'b11) begin
      bad++;
      $display("FAIL err_hold estado=%b want 11", estado);
    end
  endtask
  task automatic test_ev_and_removal();
    do_reset();
    cx_presente = 1'b1;
    tick();
    gc_in = 1'b1;
    cx_presente = 1'b0;
    tick();
    total++;
    if ({estado, erro, cnt_garrafas} !== {2'b11, 1'b1, 4'd0}) begin
      bad++;
      $display("FAIL ev_removal estado=%b erro=%b cnt=%0d want 11/1/0", estado, erro, cnt_garrafas);
    end
    gc_in = 1'b0;
  endtask
  task automatic test_reset_mid_troca();
    do_reset();
    cx_presente = 1'b1;
    tick();
    repeat (6) begin
      gc_in = 1'b1;
      tick();
      gc_in = 1'b0;
      tick();
    end
    total++;
    if (troca_cx !== 1'b1 || estado !== 2'b10) begin
      bad++;
      $display("FAIL troca_cycle2 troca=%b estado=%b want 1/10", troca_cx, estado);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({estado, esteira, troca_cx, cnt_garrafas, cx_cheia, erro} !== 10'b0) begin
      bad++;
      $display("FAIL async_reset got %b want 0", {estado, esteira, troca_cx, cnt_garrafas, cx_cheia, erro});
    end
    tick();
    reset = 1'b0;
  endtask
`ifdef CONT_CAIXAS_EN
  task automatic test_boxes_and_clear();
    do_reset();
    repeat (2) begin
      cx_presente = 1'b1;
      tick();
      repeat (6) begin
        gc_in = 1'b1;
        tick();
        gc_in = 1'b0;
        tick();
      end
      cx_presente = 1'b0;
      repeat (6) tick();
    end
    total++;
    if (total_caixas !== 8'd2) begin
      bad++;
      $display("FAIL total_caixas got %0d want 2", total_caixas);
    end
    gc_in = 1'b1;
    tick();
    gc_in = 1'b0;
    tick();
    limpa_erro = 1'b1;
    tick();
    limpa_erro = 1'b0;
    total++;
    if (erro !== 1'b0 || estado !== 2'b00) begin
      bad++;
      $display("FAIL limpa_erro erro=%b estado=%b want 0/00", erro, estado);
    end
  endtask
`endif
  initial begin
    test_reset();
    test_full_box();
    test_long_pulse_and_removal();
    test_ev_priority();
    test_ev_and_removal();
    test_reset_mid_troca();
`ifdef CONT_CAIXAS_EN
    test_boxes_and_clear();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
